// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/operand/result bundle for the sequential restoring divider
// Signals: start, dividend[7:0], divisor[3:0] (requester -> divider);
//          quotient[7:0], remainder[3:0], div_by_zero, busy, done (divider -> requester).
// Modports: master = requester side, slave = divider side.
interface seq_restoring_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic       busy;
  logic       done;
  modport master (output start, dividend, divisor,
                  input  quotient, remainder, div_by_zero, busy, done);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, div_by_zero, busy, done);
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock
// Ports: clk    - rising-edge clock
//        rst_n  - asynchronous active-low reset
//        bus    - slave modport: start/dividend/divisor in; quotient/remainder/div_by_zero/busy/done out
module seq_restoring_divider (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_shift, r_quot;
  logic [3:0] r_div, r_rem, r_part;
  logic [2:0] r_cnt;
  logic       r_dbz;
  logic [4:0] w_trial;
  logic [3:0] w_part;
  logic [7:0] w_shift;
  logic       w_ge, w_accept;
  // The partial remainder is always below the divisor, so its top bit is
  // permanently zero and only four bits are stored; the 4-bit subtraction
  // wraps to the correct result because the difference also fits.
  assign w_trial  = {r_part, r_shift[7]};
  assign w_ge     = w_trial >= {1'b0, r_div};
  assign w_part   = w_ge ? w_trial[3:0] - r_div : w_trial[3:0];
  // Quotient bits enter at the LSB as dividend bits leave at the MSB.
  assign w_shift  = {r_shift[6:0], w_ge};
  assign w_accept = (r_state == IDLE) && bus.start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    if (w_accept)             w_next = (bus.divisor == 4'd0) ? DONE : RUN;
    else if (r_state == RUN)  w_next = (r_cnt == 3'd0) ? DONE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shift <= '0;
      r_div   <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      if (bus.divisor == 4'd0) begin
        r_quot <= 8'hFF;
        r_rem  <= 4'hF;
        r_dbz  <= 1'b1;
      end else begin
        r_shift <= bus.dividend;
        r_div   <= bus.divisor;
        r_part  <= '0;
        r_cnt   <= 3'd7;
        r_dbz   <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_shift <= w_shift;
      r_part  <= w_part;
      r_cnt   <= r_cnt - 3'd1;
      if (r_cnt == 3'd0) begin
        r_quot <= w_shift;
        r_rem  <= w_part;
      end
    end
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign bus.busy        = r_state == RUN;
  assign bus.done        = r_state == DONE;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and exhaustive checks of seq_restoring_divider
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  seq_restoring_divider_if bus();
  seq_restoring_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Issues one operation, measures done latency and busy length, checks results.
  task automatic run_div(input string nm, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez,
                         input bit interfere);
    int k_done, nbusy, overlap;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    step();
    bus.start = 1'b0;
    k_done = 0;
    nbusy = 0;
    overlap = 0;
    for (int k = 1; k <= 20; k++) begin
      if (interfere) begin
        bus.start = (k >= 3 && k <= 6);
        bus.dividend = 8'd50;
        bus.divisor = 4'd5;
      end
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        k_done = k;
        break;
      end
      nbusy += int'(bus.busy);
      step();
    end
    bus.start = 1'b0;
    chk({nm, " done_latency"}, k_done, ez ? 1 : 9);
    chk({nm, " busy_cycles"}, nbusy, ez ? 0 : 8);
    chk({nm, " busy_done_overlap"}, overlap, 0);
    chk({nm, " quotient"}, int'(bus.quotient), int'(eq));
    chk({nm, " remainder"}, int'(bus.remainder), int'(er));
    chk({nm, " div_by_zero"}, int'(bus.div_by_zero), int'(ez));
    step();
    chk({nm, " done_one_cycle"}, int'(bus.done), 0);
  endtask
  initial begin
    int ndone, last;
    vt[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
    vt[1]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    vt[2]  = '{8'd13,  4'd15, 8'd0,   4'd13, 1'b0};
    vt[3]  = '{8'd0,   4'd9,  8'd0,   4'd0,  1'b0};
    vt[4]  = '{8'd100, 4'd0,  8'hFF,  4'hF,  1'b1};
    vt[5]  = '{8'd100, 4'd10, 8'd10,  4'd0,  1'b0};
    vt[6]  = '{8'd81,  4'd9,  8'd9,   4'd0,  1'b0};
    vt[7]  = '{8'd99,  4'd4,  8'd24,  4'd3,  1'b0};
    vt[8]  = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0};
    vt[9]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    vt[10] = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0};
    vt[11] = '{8'd1,   4'd0,  8'hFF,  4'hF,  1'b1};
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) step();
    chk("rst quotient", int'(bus.quotient), 0);
    chk("rst remainder", int'(bus.remainder), 0);
    chk("rst div_by_zero", int'(bus.div_by_zero), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      ndone += int'(bus.done);
    end
    chk("idle no done", ndone, 0);
    chk("idle busy", int'(bus.busy), 0);
    for (int i = 0; i < 12; i++)
      run_div($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z, 1'b0);
    run_div("ignore_start", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      ndone += int'(bus.done);
    end
    chk("hold done", ndone, 0);
    chk("hold quotient", int'(bus.quotient), 28);
    chk("hold remainder", int'(bus.remainder), 4);
    bus.start = 1'b1;
    bus.dividend = 8'd99;
    bus.divisor = 4'd4;
    step();
    ndone = 0;
    last = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done) begin
        ndone++;
        chk("b2b quotient", int'(bus.quotient), 24);
        chk("b2b remainder", int'(bus.remainder), 3);
        if (last != 0) chk("b2b interval", k - last, 10);
        last = k;
      end
      step();
    end
    chk("b2b done count", ndone, 4);
    bus.start = 1'b0;
    repeat (12) step();
    bus.start = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor = 4'd7;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    chk("midrun busy before reset", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort quotient", int'(bus.quotient), 0);
    chk("abort remainder", int'(bus.remainder), 0);
    chk("abort div_by_zero", int'(bus.div_by_zero), 0);
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      ndone += int'(bus.done) + int'(bus.busy);
    end
    chk("abort no result", ndone, 0);
    run_div("after_abort", 8'd81, 4'd9, 8'd9, 4'd0, 1'b0, 1'b0);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        run_div($sformatf("ex %0d/%0d", a, b), 8'(a), 4'(b),
                (b == 0) ? 8'hFF : 8'(a / b), (b == 0) ? 4'hF : 4'(a % b),
                b == 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
